// File: rtl/multi_pulse_counter_pkg.sv
// -----------------------------------------------------------------------------
// multi_pulse_counter_pkg
// Purpose : shared types for the multi-channel start/stop pulse counter.
// Contents: pcnt_mode_e  - per-channel counting mode (wrap or saturate)
//           PCNT_MODE_W  - width of the mode field
// Ports   : none (package)
// -----------------------------------------------------------------------------
package multi_pulse_counter_pkg;

    localparam int PCNT_MODE_W = 1;

    typedef enum logic [PCNT_MODE_W-1:0] {
        PCNT_WRAP = 1'b0,   // count >= limit rolls to 0
        PCNT_SAT  = 1'b1    // count >= limit parks at limit
    } pcnt_mode_e;

endpackage

// File: rtl/multi_pulse_counter_if.sv
// -----------------------------------------------------------------------------
// multi_pulse_counter_if
// Purpose : bundles the control, configuration and status signals of the
//           multi-channel pulse counter.
// Signals : start/stop/clear [NUM_CH]   per-channel control pulses
//           tick                         shared advance qualifier
//           mode [NUM_CH]                0 = wrap, 1 = saturate
//           limit [NUM_CH*DATA_WIDTH]    per-channel terminal value
//           snap                         snapshot request
//           count [NUM_CH*DATA_WIDTH]    live counts
//           running/tc [NUM_CH]          enable flag / terminal-count pulse
//           snap_count [NUM_CH*DATA_WIDTH] coherent snapshot
// Modports: master (drives controls, reads status), slave (the counter)
// -----------------------------------------------------------------------------
interface multi_pulse_counter_if #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8
);

    logic [NUM_CH-1:0]            start;
    logic [NUM_CH-1:0]            stop;
    logic [NUM_CH-1:0]            clear;
    logic                         tick;
    logic [NUM_CH-1:0]            mode;
    logic [NUM_CH*DATA_WIDTH-1:0] limit;
    logic                         snap;
    logic [NUM_CH*DATA_WIDTH-1:0] count;
    logic [NUM_CH-1:0]            running;
    logic [NUM_CH-1:0]            tc;
    logic [NUM_CH*DATA_WIDTH-1:0] snap_count;

    modport master (
        output start, stop, clear, tick, mode, limit, snap,
        input  count, running, tc, snap_count
    );

    modport slave (
        input  start, stop, clear, tick, mode, limit, snap,
        output count, running, tc, snap_count
    );

endinterface

// File: rtl/multi_pulse_counter_channel.sv
// -----------------------------------------------------------------------------
// multi_pulse_counter_channel
// Purpose : one start/stop pulse counter with runtime limit, wrap/saturate
//           mode, synchronous clear, tick qualifier and terminal-count pulse.
// Ports   : clk, reset (synchronous, active-high)
//           i_start, i_stop, i_clear  control pulses (clear > stop > start)
//           i_tick                    advance qualifier
//           i_mode                    PCNT_WRAP / PCNT_SAT
//           i_limit  [DATA_WIDTH]     terminal value, sampled every cycle
//           o_count  [DATA_WIDTH]     registered count
//           o_running                 registered enable flag
//           o_tc                      registered one-cycle terminal pulse
// -----------------------------------------------------------------------------
module multi_pulse_counter_channel
    import multi_pulse_counter_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic                  i_clear,
    input  logic                  i_tick,
    input  pcnt_mode_e            i_mode,
    input  logic [DATA_WIDTH-1:0] i_limit,
    output logic [DATA_WIDTH-1:0] o_count,
    output logic                  o_running,
    output logic                  o_tc
);

    logic [DATA_WIDTH-1:0] r_count;
    logic                  r_running;
    logic                  r_tc;

    logic                  w_advance;
    logic [DATA_WIDTH-1:0] w_next;
    logic                  w_tc_next;

    // A start pulse counts on its own edge, so it enables advance directly.
    assign w_advance = (i_start | r_running) & i_tick & ~i_stop & ~i_clear;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next    = r_count + 1'b1;
        w_tc_next = 1'b0;
        // ">=" rather than "==" so a limit lowered below the count recovers.
        if (r_count >= i_limit) begin
            w_next = (i_mode == PCNT_WRAP) ? '0 : i_limit;
        end
        // Saturate pulses only on arrival, not while parked at the limit.
        if (w_advance && (w_next == i_limit) &&
            ((i_mode == PCNT_WRAP) || (r_count != i_limit))) begin
            w_tc_next = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= '0;
            r_running <= 1'b0;
            r_tc      <= 1'b0;
        end else if (i_clear) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else if (i_stop) begin
            r_running <= 1'b0;
            r_tc      <= 1'b0;
        end else begin
            if (i_start) begin
                r_running <= 1'b1;
            end
            if (w_advance) begin
                r_count <= w_next;
            end
            r_tc <= w_tc_next;
        end
    end

    assign o_count   = r_count;
    assign o_running = r_running;
    assign o_tc      = r_tc;

endmodule

// File: rtl/multi_pulse_counter.sv
// -----------------------------------------------------------------------------
// multi_pulse_counter
// Purpose : NUM_CH independent start/stop pulse counters on one clock, with
//           optional coherent snapshot of all counts.
// Ports   : clk    clock, rising edge
//           reset  synchronous, active-high
//           bus    multi_pulse_counter_if.slave (controls in, status out);
//                  channel i occupies [i*DATA_WIDTH +: DATA_WIDTH] of the
//                  packed limit/count/snap_count vectors
// Config  : PCNT_SNAPSHOT_EN - when defined, snap loads snap_count with the
//           counts present before the edge; otherwise snap is ignored and
//           snap_count is tied to 0.
// -----------------------------------------------------------------------------
module multi_pulse_counter
    import multi_pulse_counter_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    multi_pulse_counter_if.slave  bus
);

    logic [NUM_CH*DATA_WIDTH-1:0] w_count;
    logic [NUM_CH-1:0]            w_running;
    logic [NUM_CH-1:0]            w_tc;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        multi_pulse_counter_channel #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_channel (
            .clk       (clk),
            .reset     (reset),
            .i_start   (bus.start[g]),
            .i_stop    (bus.stop[g]),
            .i_clear   (bus.clear[g]),
            .i_tick    (bus.tick),
            .i_mode    (pcnt_mode_e'(bus.mode[g])),
            .i_limit   (bus.limit[g*DATA_WIDTH +: DATA_WIDTH]),
            .o_count   (w_count[g*DATA_WIDTH +: DATA_WIDTH]),
            .o_running (w_running[g]),
            .o_tc      (w_tc[g])
        );
    end

    assign bus.count   = w_count;
    assign bus.running = w_running;
    assign bus.tc      = w_tc;

`ifdef PCNT_SNAPSHOT_EN
    logic [NUM_CH*DATA_WIDTH-1:0] r_snap_count;

    // w_count is already registered, so this captures the pre-edge counts
    // of every channel in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap_count <= '0;
        end else if (bus.snap) begin
            r_snap_count <= w_count;
        end
    end

    assign bus.snap_count = r_snap_count;
`else
    logic w_unused_snap;
    assign w_unused_snap  = bus.snap;
    assign bus.snap_count = '0;
`endif

endmodule

// File: tb/tb_multi_pulse_counter.sv
// -----------------------------------------------------------------------------
// tb_multi_pulse_counter
// Purpose : self-checking bench for multi_pulse_counter. A behavioural model
//           predicts every output each cycle; directed sequences also carry
//           hand-computed literal expectations. Honors PCNT_SNAPSHOT_EN.
// Ports   : none (top-level bench)
// -----------------------------------------------------------------------------
module tb_multi_pulse_counter;

    localparam int NCH = 4;
    localparam int DW  = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    multi_pulse_counter_if #(.NUM_CH(NCH), .DATA_WIDTH(DW)) bus ();

    multi_pulse_counter #(
        .NUM_CH     (NCH),
        .DATA_WIDTH (DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_cnt  [NCH];
    int m_run  [NCH];
    int m_tc   [NCH];
    int m_snap [NCH];
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        int  pre [NCH];
        int  lim;
        int  nxt;
        bit  wrap;
        bit  adv;
        for (int c = 0; c < NCH; c++) pre[c] = m_cnt[c];
        for (int c = 0; c < NCH; c++) begin
            lim  = int'(bus.limit[c*DW +: DW]);
            wrap = (bus.mode[c] == 1'b0);
            if (reset) begin
                m_cnt[c] = 0; m_run[c] = 0; m_tc[c] = 0; m_snap[c] = 0;
            end else begin
                if (bus.clear[c]) begin
                    m_cnt[c] = 0; m_tc[c] = 0;
                end else if (bus.stop[c]) begin
                    m_run[c] = 0; m_tc[c] = 0;
                end else begin
                    adv = (bus.start[c] || (m_run[c] != 0)) && (bus.tick == 1'b1);
                    if (bus.start[c]) m_run[c] = 1;
                    m_tc[c] = 0;
                    if (adv) begin
                        if (pre[c] < lim) nxt = pre[c] + 1;
                        else              nxt = wrap ? 0 : lim;
                        m_tc[c]  = (nxt == lim && (wrap || pre[c] != lim)) ? 1 : 0;
                        m_cnt[c] = nxt;
                    end
                end
`ifdef PCNT_SNAPSHOT_EN
                if (bus.snap) m_snap[c] = pre[c];
`endif
            end
        end
        m_valid = 1'b1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            for (int c = 0; c < NCH; c++) begin
                check($sformatf("count[%0d]", c),   32'(bus.count[c*DW +: DW]),      m_cnt[c]);
                check($sformatf("running[%0d]", c), 32'(bus.running[c]),            m_run[c]);
                check($sformatf("tc[%0d]", c),      32'(bus.tc[c]),                 m_tc[c]);
                check($sformatf("snap[%0d]", c),    32'(bus.snap_count[c*DW +: DW]), m_snap[c]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_limit(input int ch, input int v);
        bus.limit[ch*DW +: DW] = DW'(v);
    endtask

    function automatic logic [31:0] cnt_of(input int ch);
        return 32'(bus.count[ch*DW +: DW]);
    endfunction

    int e1_cnt [6] = '{1, 2, 3, 0, 1, 2};
    int e1_tc  [6] = '{0, 0, 1, 0, 0, 0};
    int e2_cnt [4] = '{1, 2, 2, 2};
    int e2_tc  [4] = '{0, 1, 0, 0};

    initial begin
        reset     = 1'b1;
        bus.start = '0;
        bus.stop  = '0;
        bus.clear = '0;
        bus.tick  = 1'b1;
        bus.mode  = '0;
        bus.limit = '0;
        bus.snap  = 1'b0;
        edges(2);
        check("reset count",   32'(bus.count),   0);
        check("reset running", 32'(bus.running), 0);
        check("reset tc",      32'(bus.tc),      0);
        reset = 1'b0;

        // 1: WRAP limit 3 on ch0
        set_limit(0, 3);
        bus.start[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            edges(1);
            bus.start[0] = 1'b0;
            check("t1 count0", cnt_of(0), e1_cnt[i]);
            check("t1 tc0", 32'(bus.tc[0]), e1_tc[i]);
        end

        // 2: SATURATE limit 2 on ch1, then stop
        bus.mode[1] = 1'b1;
        set_limit(1, 2);
        bus.start[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            edges(1);
            bus.start[1] = 1'b0;
            check("t2 count1", cnt_of(1), e2_cnt[i]);
            check("t2 tc1", 32'(bus.tc[1]), e2_tc[i]);
            check("t2 running1", 32'(bus.running[1]), 1);
        end
        bus.stop[1] = 1'b1;
        edges(1);
        bus.stop[1] = 1'b0;
        check("t2 stop running1", 32'(bus.running[1]), 0);
        check("t2 stop count1", cnt_of(1), 2);

        // 3: start&stop, then clear&start on ch2
        set_limit(2, 10);
        bus.start[2] = 1'b1;
        bus.stop[2]  = 1'b1;
        edges(1);
        bus.stop[2]  = 1'b0;
        check("t3 ss running2", 32'(bus.running[2]), 0);
        check("t3 ss count2", cnt_of(2), 0);
        edges(1);
        bus.start[2] = 1'b0;
        edges(1);
        check("t3 count2", cnt_of(2), 2);
        bus.clear[2] = 1'b1;
        bus.start[2] = 1'b1;
        edges(1);
        bus.clear[2] = 1'b0;
        bus.start[2] = 1'b0;
        check("t3 clr count2", cnt_of(2), 0);
        check("t3 clr running2", 32'(bus.running[2]), 1);
        edges(1);
        check("t3 resume count2", cnt_of(2), 1);

        // 4: tick gating and limit lowered below count on ch3
        set_limit(3, 5);
        bus.start[3] = 1'b1;
        edges(1);
        bus.start[3] = 1'b0;
        edges(3);
        check("t4 count3", cnt_of(3), 4);
        bus.tick = 1'b0;
        for (int i = 0; i < 3; i++) begin
            edges(1);
            check("t4 frozen count3", cnt_of(3), 4);
            check("t4 frozen tc3", 32'(bus.tc[3]), 0);
        end
        set_limit(3, 1);
        bus.tick = 1'b1;
        edges(1);
        check("t4 lowered count3", cnt_of(3), 0);
        check("t4 lowered tc3", 32'(bus.tc[3]), 0);
        edges(1);
        check("t4 arrive count3", cnt_of(3), 1);
        check("t4 arrive tc3", 32'(bus.tc[3]), 1);

        // 5: reset mid-count on ch1 while others run
        bus.mode[1] = 1'b0;
        set_limit(1, 50);
        bus.clear[1] = 1'b1;
        edges(1);
        bus.clear[1] = 1'b0;
        bus.start[1] = 1'b1;
        edges(1);
        bus.start[1] = 1'b0;
        edges(2);
        check("t5 count1", cnt_of(1), 3);
        reset = 1'b1;
        edges(1);
        reset = 1'b0;
        check("t5 reset count", 32'(bus.count), 0);
        check("t5 reset running", 32'(bus.running), 0);

        // 6: snapshot of ch0 while counting
        bus.start[0] = 1'b1;
        edges(1);
        bus.start[0] = 1'b0;
        edges(1);
        bus.snap = 1'b1;
        edges(1);
        bus.snap = 1'b0;
        check("t6 count0", cnt_of(0), 3);
`ifdef PCNT_SNAPSHOT_EN
        check("t6 snap", 32'(bus.snap_count), 2);
`else
        check("t6 snap", 32'(bus.snap_count), 0);
`endif
        edges(1);

        // 7: full-range WRAP on ch2, max -> 0
        set_limit(2, 255);
        bus.start[2] = 1'b1;
        edges(1);
        bus.start[2] = 1'b0;
        edges(254);
        check("t7 max count2", cnt_of(2), 255);
        check("t7 max tc2", 32'(bus.tc[2]), 1);
        edges(1);
        check("t7 wrap count2", cnt_of(2), 0);
        check("t7 wrap tc2", 32'(bus.tc[2]), 0);

        // 8: limit 0 WRAP on ch3 pulses tc every advance
        set_limit(3, 0);
        bus.start[3] = 1'b1;
        edges(1);
        bus.start[3] = 1'b0;
        check("t8 count3", cnt_of(3), 0);
        check("t8 tc3", 32'(bus.tc[3]), 1);
        edges(1);
        check("t8 count3 again", cnt_of(3), 0);
        check("t8 tc3 again", 32'(bus.tc[3]), 1);

        edges(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
